pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, the duty/period resolution of the matching PWM generator; counters are WIDTH+1 bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of flip-flops in the input synchronizer (minimum 2).
REQ-003 The block SHALL have parameter FILTER_LEN, default 3, the glitch-filter length in clk cycles (used only when PWM_CAPTURE_FILTER_EN is defined).
REQ-004 clk  input  1  the single clock, rising-edge active.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 PWM_in  input  1  asynchronous PWM waveform to be measured.
REQ-007 duty_out  output  WIDTH+1  high-time of the last complete period, in clk cycles.
REQ-008 period_out  output  WIDTH+1  rising-to-rising period of the last complete period, in clk cycles.
REQ-009 valid  output  1  one-cycle pulse; duty_out/period_out were updated this cycle.
REQ-010 stuck  output  1  level; no rising edge seen within 2^(WIDTH+1)-1 cycles.

Function
REQ-011 PWM_in SHALL pass through SYNC_STAGES flip-flops; "level" is the synchronizer output (or filter output when enabled); "rise" is level=1 while the previous level=0.
REQ-012 The FSM SHALL have states IDLE (no reference edge), HIGH (level=1 since last rise), and LOW (level has fallen since last rise).
REQ-013 IDLE: on rise, go to HIGH, set period_cnt=1 and high_cnt=1, clear stuck, and produce no valid.
REQ-014 HIGH/LOW: each cycle period_cnt SHALL increment; high_cnt SHALL increment when level=1; a falling level moves HIGH->LOW.
REQ-015 LOW on rise: the block SHALL register duty_out=high_cnt and period_out=period_cnt, pulse valid, set both counters to 1, and go to HIGH.
REQ-016 A rise detected in HIGH is impossible by construction and SHALL be treated as in REQ-015.
REQ-017 Timeout: when period_cnt reaches 2^(WIDTH+1)-1 in HIGH or LOW, the block SHALL set stuck=1, load period_out=0, load duty_out=all-ones if level=1 (100%) else 0 (0%), pulse valid, and go to IDLE.
REQ-018 In IDLE with stuck=1, no further valid pulses SHALL occur until the next rise.
REQ-019 Latency: valid SHALL assert on the clk edge SYNC_STAGES+1 edges after the first edge that samples PWM_in high (plus FILTER_LEN with the filter enabled).
REQ-020 Counters SHALL never wrap; timeout preempts overflow.
REQ-021 duty_out and period_out SHALL hold their value between valid pulses.

Reset
REQ-022 rst SHALL asynchronously force state=IDLE, the synchronizer and filter to 0, the counters to 0, duty_out=0, period_out=0, valid=0, and stuck=0.
REQ-023 A reset asserted mid-period SHALL discard the partial measurement; the first valid after release requires two rises.

Configuration
REQ-024 With PWM_CAPTURE_FILTER_EN defined, level SHALL change only after the synchronizer output differs from level for FILTER_LEN consecutive cycles; shorter pulses SHALL be ignored.
REQ-025 Without PWM_CAPTURE_FILTER_EN, level SHALL equal the synchronizer output, the filter logic SHALL be absent, and FILTER_LEN SHALL be ignored.

Structure
REQ-026 Package pwm_capture_pkg SHALL hold the FSM state enum (IDLE/HIGH/LOW) and the default WIDTH/SYNC_STAGES/FILTER_LEN constants.
REQ-027 Sub-module pwm_sync_filter SHALL contain the synchronizer and the optional glitch filter and SHALL output level.

Verification
REQ-028 Loopback: the team PWM generator with WIDTH=4 and count-up, input 5 -> after the second rise, every period gives valid, duty_out=5, period_out=16.
REQ-029 Duty change: the generator input is changed from 5 to 12 mid-run -> within two periods, duty_out=12, period_out=16; no valid shows duty >16.
REQ-030 Static: PWM_in held 1 for 2^(WIDTH+1) cycles (WIDTH=4) -> stuck=1, a single valid, duty_out=31, period_out=0; held 0 instead -> duty_out=0.
REQ-031 Reset mid-period: rst pulsed during HIGH -> all outputs 0 immediately (asynchronously); the first valid follows the second subsequent rise.
REQ-032 Filter (macro on, FILTER_LEN=3): a 2-cycle high glitch in a low phase -> measurement unchanged; a 3-cycle pulse is counted, with latency increased by 3.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and default sizing for the PWM capture block.
// Optional glitch filter is enabled by defining PWM_CAPTURE_FILTER_EN.
package pwm_capture_pkg;

    localparam int DEF_WIDTH       = 10;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILTER_LEN  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Filter counter only has to reach len-1.
    function automatic int filt_cnt_bits(input int len);
        return (len < 3) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/pwm_capture_sync_filter.sv
// Input synchronizer for PWM_in plus an optional glitch filter (PWM_CAPTURE_FILTER_EN).
// o_level is the cleaned-up waveform seen by the measurement FSM.
module pwm_sync_filter
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef PWM_CAPTURE_FILTER_EN
    ,parameter int FILTER_LEN = DEF_FILTER_LEN
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int                CW      = filt_cnt_bits(FILTER_LEN);
    localparam logic [CW-1:0]     FLT_ONE = 1;
    localparam logic [CW-1:0]     FLT_TC  = CW'(FILTER_LEN - 1);

    logic [CW-1:0] r_flt_cnt;
    logic          r_level;

    // Level follows the synchronizer only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flt_cnt <= '0;
            r_level   <= 1'b0;
        end else if (w_sync != r_level) begin
            if (r_flt_cnt == FLT_TC) begin
                r_level   <= w_sync;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_ONE;
            end
        end else begin
            r_flt_cnt <= '0;
        end
    end

    assign o_level = r_level;
`else
    assign o_level = w_sync;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input.
// Build with PWM_CAPTURE_FILTER_EN defined to add the FILTER_LEN glitch filter.
//
// state | meaning
// IDLE  | no reference rising edge yet (after reset or timeout)
// HIGH  | level has been 1 since the last rise
// LOW   | level has fallen since the last rise, waiting for the next rise
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           PWM_in,
    output logic [WIDTH:0] duty_out,
    output logic [WIDTH:0] period_out,
    output logic           valid,
    output logic           stuck
);

    localparam logic [WIDTH:0] CNT_MAX = '1;
    localparam logic [WIDTH:0] CNT_ONE = 1;

    logic w_level;
    logic r_level;
    logic r_level_prev;
    logic w_rise;

    state_t         r_state,      w_state_nxt;
    logic [WIDTH:0] r_period_cnt, w_period_cnt_nxt;
    logic [WIDTH:0] r_high_cnt,   w_high_cnt_nxt;
    logic [WIDTH:0] r_duty,       w_duty_nxt;
    logic [WIDTH:0] r_period,     w_period_nxt;
    logic           r_valid,      w_valid_nxt;
    logic           r_stuck,      w_stuck_nxt;

    pwm_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
        ,.FILTER_LEN (FILTER_LEN)
`endif
    ) u_sync_filter (
        .clk     (clk),
        .rst     (rst),
        .i_pwm   (PWM_in),
        .o_level (w_level)
    );

    // One level register ahead of edge detection so valid lands SYNC_STAGES+1 edges after sampling.
    assign w_rise = r_level & ~r_level_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_state      <= IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_duty       <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_level      <= w_level;
            r_level_prev <= r_level;
            r_state      <= w_state_nxt;
            r_period_cnt <= w_period_cnt_nxt;
            r_high_cnt   <= w_high_cnt_nxt;
            r_duty       <= w_duty_nxt;
            r_period     <= w_period_nxt;
            r_valid      <= w_valid_nxt;
            r_stuck      <= w_stuck_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_period_cnt_nxt = r_period_cnt;
        w_high_cnt_nxt   = r_high_cnt;
        w_duty_nxt       = r_duty;
        w_period_nxt     = r_period;
        w_valid_nxt      = 1'b0;
        w_stuck_nxt      = r_stuck;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt      = HIGH;
                    w_period_cnt_nxt = CNT_ONE;
                    w_high_cnt_nxt   = CNT_ONE;
                    w_stuck_nxt      = 1'b0;
                end
            end

            HIGH, LOW: begin
                if (w_rise) begin
                    // A rise at period_cnt==CNT_MAX is still a legal period, so it wins over timeout.
                    w_duty_nxt       = r_high_cnt;
                    w_period_nxt     = r_period_cnt;
                    w_valid_nxt      = 1'b1;
                    w_period_cnt_nxt = CNT_ONE;
                    w_high_cnt_nxt   = CNT_ONE;
                    w_state_nxt      = HIGH;
                end else if (r_period_cnt == CNT_MAX) begin
                    w_stuck_nxt      = 1'b1;
                    w_period_nxt     = '0;
                    w_duty_nxt       = r_level ? CNT_MAX : '0;
                    w_valid_nxt      = 1'b1;
                    w_period_cnt_nxt = '0;
                    w_high_cnt_nxt   = '0;
                    w_state_nxt      = IDLE;
                end else begin
                    w_period_cnt_nxt = r_period_cnt + CNT_ONE;
                    if (r_level) begin
                        w_high_cnt_nxt = r_high_cnt + CNT_ONE;
                    end
                    if ((r_state == HIGH) && !r_level) begin
                        w_state_nxt = LOW;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign duty_out   = r_duty;
    assign period_out = r_period;
    assign valid      = r_valid;
    assign stuck      = r_stuck;

endmodule
